// File: rtl/ahb5_pkg.sv
// Shared AHB5 types: transfer/burst/size encodings, response codes, subordinate
// state enum and the little-endian byte-lane decode used by memory targets.
package ahb5_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3,
    HSIZE_W4    = 3'd4,
    HSIZE_W8    = 3'd5,
    HSIZE_W16   = 3'd6,
    HSIZE_W32   = 3'd7
  } hsize_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    SLV_IDLE = 2'd0,
    SLV_WAIT = 2'd1,
    SLV_ERR1 = 2'd2,
    SLV_ERR2 = 2'd3
  } ahb5_slv_state_t;

  // Byte lanes touched by an aligned transfer; lane 0 is HWDATA[7:0].
  function automatic logic [3:0] lane_enables(input hsize_t size, input logic [1:0] lane);
    case (size)
      HSIZE_BYTE: lane_enables = 4'b0001 << lane;
      HSIZE_HALF: lane_enables = lane[1] ? 4'b1100 : 4'b0011;
      default:    lane_enables = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb5_slave_mem_array.sv
// Word-wide storage with a byte-enabled synchronous write port and an
// asynchronous read port; contents are never reset.
module ahb5_slave_mem_array #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/ahb5_slave_mem.sv
// AHB5 subordinate fronting an on-chip word memory: captures address phases,
// inserts WAIT_STATES wait cycles per OKAY transfer and answers illegal ones with ERROR.
module ahb5_slave_mem
  import ahb5_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           MEM_DEPTH   = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output ahb5_slv_state_t       dbg_state_o
);

  localparam int unsigned           IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * 4);
  localparam logic [ADDR_WIDTH-1:0] OFS_MASK  = MEM_BYTES - 1'b1;
  localparam logic [3:0]            WS_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  ahb5_slv_state_t  state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             dp_q, dp_d;
  logic             write_q, write_d;
  hsize_t           size_q, size_d;
  logic [1:0]       lane_q, lane_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             hreadyout_q, hreadyout_d;
  logic             hresp_q, hresp_d;

  logic             capture;
  logic             legal;
  logic             mem_we;
  logic [3:0]       mem_be;
  logic [31:0]      mem_rdata;
  logic             unused_sig;

  // Handshake: an address phase is taken on the edge where HSEL && HREADY &&
  // HTRANS[1]; its data phase ends on the first later edge with HREADYOUT high.
  assign capture = HSEL && HREADY && HTRANS[1];

  // BASE_ADDR is aligned to the array size, so range check is a high-bit compare.
  always_comb begin
    legal = ((HADDR & ~OFS_MASK) == BASE_ADDR);
    case (hsize_t'(HSIZE))
      HSIZE_BYTE: ;
      HSIZE_HALF: if (HADDR[0]) legal = 1'b0;
      HSIZE_WORD: if (HADDR[1:0] != 2'b00) legal = 1'b0;
      default:    legal = 1'b0;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= SLV_IDLE;
      cnt_q       <= '0;
      dp_q        <= 1'b0;
      write_q     <= 1'b0;
      size_q      <= HSIZE_BYTE;
      lane_q      <= '0;
      idx_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dp_q        <= dp_d;
      write_q     <= write_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      idx_q       <= idx_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dp_d    = dp_q;
    write_d = write_q;
    size_d  = size_q;
    lane_d  = lane_q;
    idx_d   = idx_q;
    unique case (state_q)
      SLV_IDLE: dp_d = 1'b0;
      SLV_WAIT: begin
        if (cnt_q == 4'd0) state_d = SLV_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      SLV_ERR1: state_d = SLV_ERR2;
      SLV_ERR2: state_d = SLV_IDLE;
      default:  state_d = SLV_IDLE;
    endcase
    // A capture overrides the above, which is what gives back-to-back pipelining.
    if (capture) begin
      if (legal) begin
        dp_d    = 1'b1;
        write_d = HWRITE;
        size_d  = hsize_t'(HSIZE);
        lane_d  = HADDR[1:0];
        idx_d   = HADDR[IDX_W+1:2];
        if (WAIT_STATES > 0) begin
          state_d = SLV_WAIT;
          cnt_d   = WS_LOAD;
        end else begin
          state_d = SLV_IDLE;
          cnt_d   = '0;
        end
      end else begin
        state_d = SLV_ERR1;
        dp_d    = 1'b0;
        cnt_d   = '0;
      end
    end
  end

  always_comb begin
    hreadyout_d = (state_d == SLV_IDLE) || (state_d == SLV_ERR2);
    hresp_d     = (state_d == SLV_ERR1) || (state_d == SLV_ERR2);
    mem_we      = dp_q && write_q && hreadyout_q && (hresp_q == HRESP_OKAY) && !HRESET;
    mem_be      = lane_enables(size_q, lane_q);
  end

  ahb5_slave_mem_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk_i   (HCLK),
    .we_i    (mem_we),
    .be_i    (mem_be),
    .idx_i   (idx_q),
    .wdata_i (HWDATA),
    .rdata_o (mem_rdata)
  );

  assign HREADYOUT   = hreadyout_q;
  assign HRESP       = hresp_q;
  assign HRDATA      = (dp_q && !write_q) ? mem_rdata : '0;
  assign dbg_state_o = state_q;
  assign unused_sig  = ^{HBURST, HPROT, HTRANS[0]};

endmodule

// File: tb/tb_ahb5_slave_mem.sv
// Bench for ahb5_slave_mem: two instances (0 and 3 wait states, different bases)
// checked each cycle against a transfer-level model plus literal read expectations.
module tb_ahb5_slave_mem;
  import ahb5_pkg::*;

  logic            clk;
  logic            hreset    [2];
  logic            hsel      [2];
  logic [31:0]     haddr     [2];
  logic [1:0]      htrans    [2];
  logic            hwrite    [2];
  logic [2:0]      hsize     [2];
  logic [2:0]      hburst    [2];
  logic [3:0]      hprot     [2];
  logic [31:0]     hwdata    [2];
  logic            hready    [2];
  logic            stall     [2];
  logic            hreadyout [2];
  logic            hresp     [2];
  logic [31:0]     hrdata    [2];
  ahb5_slv_state_t dbg_state [2];

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;
  logic [32:0] exp_q[$];

  // model state: cycles left in the current response and what it is
  int          rem   [2];
  logic        err_m [2];
  logic        rd_m  [2];
  logic        wr_m  [2];
  int          idx_m [2];
  logic [3:0]  be_m  [2];
  logic [31:0] mm    [2][256];
  logic [3:0]  kn    [2][256];
  logic        m_rdy;

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? 32'h0000_0000 : 32'h0001_0000;
  endfunction

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int d = 0; d < 2; d++) hready[d] = stall[d] ? 1'b0 : hreadyout[d];
  end

  ahb5_slave_mem #(.WAIT_STATES(0), .BASE_ADDR(32'h0000_0000)) u_dut0 (
    .HCLK(clk), .HRESET(hreset[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]), .HPROT(hprot[0]),
    .HWDATA(hwdata[0]), .HREADY(hready[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]),
    .HRDATA(hrdata[0]), .dbg_state_o(dbg_state[0])
  );

  ahb5_slave_mem #(.WAIT_STATES(3), .BASE_ADDR(32'h0001_0000)) u_dut3 (
    .HCLK(clk), .HRESET(hreset[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]), .HPROT(hprot[1]),
    .HWDATA(hwdata[1]), .HREADY(hready[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]),
    .HRDATA(hrdata[1]), .dbg_state_o(dbg_state[1])
  );

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic legal_of(input int d, input logic [31:0] a, input logic [2:0] sz);
    logic [31:0] off;
    off = a - base_of(d);
    if (a < base_of(d) || off >= 32'd1024) return 1'b0;
    if (sz > 3'd2) return 1'b0;
    if (sz == 3'd1 && a[0]) return 1'b0;
    if (sz == 3'd2 && a[1:0] != 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] be_of(input logic [31:0] a, input logic [2:0] sz);
    if (sz == 3'd0) return 4'b0001 << a[1:0];
    if (sz == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // ---------------- reference model ----------------
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (hreset[d]) begin
        rem[d] = 0; err_m[d] = 1'b0; rd_m[d] = 1'b0; wr_m[d] = 1'b0;
      end else begin
        m_rdy = (rem[d] == 0) || (rem[d] == 1);
        if (rem[d] == 1 && !err_m[d] && wr_m[d]) begin
          for (int b = 0; b < 4; b++)
            if (be_m[d][b]) mm[d][idx_m[d]][8*b +: 8] = hwdata[d][8*b +: 8];
          kn[d][idx_m[d]] = kn[d][idx_m[d]] | be_m[d];
        end
        if (rem[d] > 0) rem[d] = rem[d] - 1;
        if (hsel[d] && !stall[d] && m_rdy && htrans[d][1]) begin
          if (legal_of(d, haddr[d], hsize[d])) begin
            err_m[d] = 1'b0; rem[d] = ws_of(d) + 1;
            wr_m[d] = hwrite[d]; rd_m[d] = !hwrite[d];
            idx_m[d] = int'((haddr[d] - base_of(d)) >> 2);
            be_m[d] = be_of(haddr[d], hsize[d]);
          end else begin
            err_m[d] = 1'b1; rem[d] = 2; wr_m[d] = 1'b0; rd_m[d] = 1'b0;
          end
        end
        if (rem[d] == 0) err_m[d] = 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        logic exp_rd;
        exp_rd = (rem[d] > 0) && rd_m[d] && !err_m[d];
        chk($sformatf("hreadyout%0d", d), 32'(hreadyout[d]), 32'((rem[d] == 0) || (rem[d] == 1)));
        chk($sformatf("hresp%0d", d), 32'(hresp[d]), 32'(err_m[d]));
        if (!exp_rd) chk($sformatf("hrdata_zero%0d", d), hrdata[d], 32'h0);
        else if (kn[d][idx_m[d]] == 4'hF) chk($sformatf("hrdata%0d", d), hrdata[d], mm[d][idx_m[d]]);
        if (exp_rd && rem[d] == 1 && exp_q.size() > 0 && int'(exp_q[0][32]) == d) begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk($sformatf("sb_read%0d", d), hrdata[d], e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_op(input int d, input logic [1:0] tr, input logic [31:0] a,
                        input logic w, input logic [2:0] sz, input logic [31:0] wd);
    int n;
    logic done;
    hsel[d] = 1'b1; htrans[d] = tr; haddr[d] = a; hwrite[d] = w; hsize[d] = sz;
    n = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (hready[d]) done = 1'b1;
      else if (++n > 64) begin
        n_checks++; n_errors++;
        $display("FAIL hready_timeout%0d: got stuck low for %0d cycles required high", d, n);
        done = 1'b1;
      end
    end
    @(posedge clk); #1;
    hwdata[d] = wd;
  endtask

  task automatic set_idle(input int d);
    htrans[d] = HTRANS_IDLE;
  endtask

  task automatic expect_read(input int d, input logic [31:0] v);
    exp_q.push_back({1'(d), v});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] b1;
    b1 = base_of(1);
    for (int d = 0; d < 2; d++) begin
      hreset[d] = 1'b1; hsel[d] = 1'b0; haddr[d] = '0; htrans[d] = HTRANS_IDLE;
      hwrite[d] = 1'b0; hsize[d] = 3'd2; hburst[d] = 3'd0; hprot[d] = 4'h3;
      hwdata[d] = '0; stall[d] = 1'b0; rem[d] = 0; err_m[d] = 1'b0;
      rd_m[d] = 1'b0; wr_m[d] = 1'b0; idx_m[d] = 0; be_m[d] = '0;
      for (int i = 0; i < 256; i++) begin mm[d][i] = '0; kn[d][i] = '0; end
    end
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_hreadyout", 32'(hreadyout[1]), 32'd1);
    chk("reset_hresp", 32'(hresp[1]), 32'd0);
    chk("reset_hrdata", hrdata[1], 32'h0);
    chk("reset_state", 32'(dbg_state[0]), 32'(SLV_IDLE));
    @(posedge clk); #1;
    hreset[0] = 1'b0; hreset[1] = 1'b0;

    // word write / read, zero wait states
    bus_op(0, HTRANS_NONSEQ, 32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF);
    expect_read(0, 32'hDEAD_BEEF);
    bus_op(0, HTRANS_NONSEQ, 32'h10, 1'b0, 3'd2, 32'h0);
    // byte then half writes
    bus_op(0, HTRANS_NONSEQ, 32'h20, 1'b1, 3'd0, {4{8'h11}});
    bus_op(0, HTRANS_NONSEQ, 32'h21, 1'b1, 3'd0, {4{8'h22}});
    bus_op(0, HTRANS_NONSEQ, 32'h22, 1'b1, 3'd0, {4{8'h33}});
    bus_op(0, HTRANS_NONSEQ, 32'h23, 1'b1, 3'd0, {4{8'h44}});
    expect_read(0, 32'h4433_2211);
    bus_op(0, HTRANS_NONSEQ, 32'h20, 1'b0, 3'd2, 32'h0);
    bus_op(0, HTRANS_NONSEQ, 32'h22, 1'b1, 3'd1, {2{16'hABCD}});
    expect_read(0, 32'hABCD_2211);
    bus_op(0, HTRANS_NONSEQ, 32'h20, 1'b0, 3'd2, 32'h0);
    bus_op(0, HTRANS_IDLE, 32'h0, 1'b0, 3'd2, 32'h0);

    // three wait states: low, low, low, high with stable read data
    bus_op(1, HTRANS_NONSEQ, b1 + 32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF);
    bus_op(1, HTRANS_NONSEQ, b1 + 32'h10, 1'b0, 3'd2, 32'h0);
    set_idle(1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("ws3_hreadyout_c%0d", k), 32'(hreadyout[1]), (k == 3) ? 32'd1 : 32'd0);
      chk($sformatf("ws3_hrdata_c%0d", k), hrdata[1], 32'hDEAD_BEEF);
    end

    // ERROR responses leave memory untouched
    bus_op(0, HTRANS_NONSEQ, 32'h0, 1'b1, 3'd2, 32'h0BAD_F00D);
    bus_op(0, HTRANS_NONSEQ, 32'h2, 1'b1, 3'd2, 32'hFFFF_FFFF);
    set_idle(0);
    @(negedge clk);
    chk("err1_misalign_ready", 32'(hreadyout[0]), 32'd0);
    chk("err1_misalign_resp", 32'(hresp[0]), 32'd1);
    @(negedge clk);
    chk("err2_misalign_ready", 32'(hreadyout[0]), 32'd1);
    chk("err2_misalign_resp", 32'(hresp[0]), 32'd1);
    expect_read(0, 32'h0BAD_F00D);
    bus_op(0, HTRANS_NONSEQ, 32'h0, 1'b0, 3'd2, 32'h0);
    bus_op(0, HTRANS_IDLE, 32'h0, 1'b0, 3'd2, 32'h0);

    bus_op(1, HTRANS_NONSEQ, b1, 1'b1, 3'd2, 32'h600D_CAFE);
    bus_op(1, HTRANS_NONSEQ, b1 + 32'd1024, 1'b1, 3'd2, 32'h1111_1111);
    set_idle(1);
    @(negedge clk);
    chk("err1_range_ready", 32'(hreadyout[1]), 32'd0);
    chk("err1_range_resp", 32'(hresp[1]), 32'd1);
    @(negedge clk);
    chk("err2_range_ready", 32'(hreadyout[1]), 32'd1);
    chk("err2_range_resp", 32'(hresp[1]), 32'd1);
    expect_read(1, 32'h600D_CAFE);
    bus_op(1, HTRANS_NONSEQ, b1, 1'b0, 3'd2, 32'h0);

    // INCR4 write with a BUSY beat, reads around an external stall
    hburst[1] = HBURST_INCR4;
    bus_op(1, HTRANS_NONSEQ, b1 + 32'h40, 1'b1, 3'd2, 32'hA0A0_0040);
    bus_op(1, HTRANS_SEQ,    b1 + 32'h44, 1'b1, 3'd2, 32'hA1A1_0044);
    bus_op(1, HTRANS_BUSY,   b1 + 32'h48, 1'b1, 3'd2, 32'h0);
    bus_op(1, HTRANS_SEQ,    b1 + 32'h48, 1'b1, 3'd2, 32'hA2A2_0048);
    bus_op(1, HTRANS_SEQ,    b1 + 32'h4C, 1'b1, 3'd2, 32'hA3A3_004C);
    expect_read(1, 32'hA0A0_0040);
    expect_read(1, 32'hA1A1_0044);
    expect_read(1, 32'hA2A2_0048);
    expect_read(1, 32'hA3A3_004C);
    bus_op(1, HTRANS_NONSEQ, b1 + 32'h40, 1'b0, 3'd2, 32'h0);
    bus_op(1, HTRANS_SEQ,    b1 + 32'h44, 1'b0, 3'd2, 32'h0);
    bus_op(1, HTRANS_IDLE,   b1, 1'b0, 3'd2, 32'h0);
    stall[1] = 1'b1;
    htrans[1] = HTRANS_NONSEQ; haddr[1] = b1 + 32'h48; hwrite[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall_no_capture_c%0d", k), 32'(hreadyout[1]), 32'd1);
      @(posedge clk); #1;
    end
    stall[1] = 1'b0;
    bus_op(1, HTRANS_NONSEQ, b1 + 32'h48, 1'b0, 3'd2, 32'h0);
    bus_op(1, HTRANS_SEQ,    b1 + 32'h4C, 1'b0, 3'd2, 32'h0);
    bus_op(1, HTRANS_IDLE,   b1, 1'b0, 3'd2, 32'h0);
    hburst[1] = HBURST_SINGLE;

    // reset during a three-wait write abandons it
    bus_op(1, HTRANS_NONSEQ, b1 + 32'h50, 1'b1, 3'd2, 32'h1234_5678);
    bus_op(1, HTRANS_IDLE,   b1, 1'b0, 3'd2, 32'h0);
    bus_op(1, HTRANS_NONSEQ, b1 + 32'h50, 1'b1, 3'd2, 32'hFFFF_0000);
    set_idle(1);
    @(posedge clk); #1;
    hreset[1] = 1'b1;
    @(posedge clk); #1;
    hreset[1] = 1'b0;
    @(negedge clk);
    chk("rst_mid_hreadyout", 32'(hreadyout[1]), 32'd1);
    chk("rst_mid_hresp", 32'(hresp[1]), 32'd0);
    expect_read(1, 32'h1234_5678);
    bus_op(1, HTRANS_NONSEQ, b1 + 32'h50, 1'b0, 3'd2, 32'h0);
    bus_op(1, HTRANS_IDLE,   b1, 1'b0, 3'd2, 32'h0);

    // prefill a window, then random traffic
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++)
        bus_op(d, HTRANS_NONSEQ, base_of(d) + 32'(4 * i), 1'b1, 3'd2, $urandom);
      for (int n = 0; n < 250; n++) begin
        int r;
        logic [1:0]  tr;
        logic [2:0]  sz;
        logic [31:0] off;
        logic [31:0] a;
        r  = $urandom_range(0, 9);
        tr = (r < 1) ? HTRANS_IDLE : (r < 2) ? HTRANS_BUSY : (r < 6) ? HTRANS_NONSEQ : HTRANS_SEQ;
        sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        off = 32'($urandom_range(0, 255));
        if (sz <= 3'd2 && $urandom_range(0, 3) != 0) off = off & ~((32'd1 << sz) - 32'd1);
        r = $urandom_range(0, 19);
        if (r == 0)                a = base_of(d) + 32'd1024 + off;
        else if (r == 1 && d == 1) a = base_of(d) - 32'd256 + off;
        else                       a = base_of(d) + off;
        hburst[d] = 3'($urandom_range(0, 7));
        hprot[d]  = 4'($urandom_range(0, 15));
        bus_op(d, tr, a, 1'($urandom_range(0, 1)), sz, $urandom);
      end
      bus_op(d, HTRANS_IDLE, base_of(d), 1'b0, 3'd2, 32'h0);
    end

    repeat (6) @(posedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #600000;
    n_errors++;
    $display("FAIL global_timeout: simulation did not end within budget");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ahb5_slave_mem.md
# ahb5_slave_mem

Synthesisable AHB5 subordinate with on-chip word memory. It is the downstream consumer of the AHB5 master VIP driver: it replaces the dummy slave driver as the real target on the interface. It accepts pipelined address/data-phase transfers, inserts a configurable number of wait states, and performs byte-lane writes and word reads. Illegal transfers get the two-cycle AHB ERROR response.

## Interface
- ADDR_WIDTH, 32, HADDR width
- DATA_WIDTH, 32, HWDATA/HRDATA width; fixed at 32 in this revision
- MEM_DEPTH, 256, number of 32-bit words; power of two
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to MEM_DEPTH*4
- WAIT_STATES, 0, wait cycles inserted per OKAY data phase (0..15)
- HCLK  in  1  single clock; all logic on rising edge
- HRESET  in  1  synchronous, active-high reset
- HSEL  in  1  subordinate select
- HADDR  in  ADDR_WIDTH  byte address
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  in  1  1=write
- HSIZE  in  3  transfer size; 0=byte, 1=half, 2=word
- HBURST  in  3  burst type; accepted, not interpreted
- HPROT  in  4  ignored
- HWDATA  in  DATA_WIDTH  write data, valid in data phase
- HREADY  in  1  bus-wide ready from the interconnect/mux
- HREADYOUT  out  1  this subordinate's ready
- HRESP  out  1  0=OKAY, 1=ERROR
- HRDATA  out  DATA_WIDTH  read data

## Operation
- **Address-phase capture:** an address phase is accepted on a rising edge when HSEL && HREADY && HTRANS[1].
  - Captured: HADDR, HWRITE, HSIZE.
  - Legality is evaluated at capture.
- **Illegal transfer** (any one of):
  - HADDR outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH*4-1]
  - HSIZE>2
  - misaligned: HSIZE=1 with HADDR[0]=1, or HSIZE=2 with HADDR[1:0]≠0
- **IDLE, BUSY, or HSEL=0 with HREADY=1:** no data phase. HREADYOUT=1, HRESP=0 next cycle.
- **States:**
  - IDLE: no data phase pending.
  - WAIT: legal data phase, counter running.
  - ERR1, ERR2: error response cycles.
- **Transitions:**
  - IDLE→WAIT on legal capture when WAIT_STATES>0; count loads WAIT_STATES-1.
  - IDLE→IDLE on legal capture with WAIT_STATES=0; the data phase completes in the following cycle.
  - Any state→ERR1 on illegal capture.
  - ERR1→ERR2.
  - WAIT decrements; at 0 it goes to the completion cycle.
  - A new address may be captured in the same cycle a data phase completes (HREADYOUT=1), giving back-to-back pipelining.
- **Write:** memory written on the edge ending the data phase (HREADYOUT=1 && HRESP=0).
  - Word index = (addr-BASE_ADDR)>>2.
  - Little-endian byte enables: byte → lane addr[1:0]; half → lanes {addr[1],0}+{0,1}; word → all lanes.
  - Unenabled bytes are unchanged.
- **Read:** HRDATA = mem[word index] throughout the read data phase, including wait cycles. HRDATA=0 at all other times.
- **Read-after-write:** write-then-read to the same address back-to-back returns the new data. The write commits before the read data phase begins.
- **ERROR response:**
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
  - No memory update. HRDATA=0.
  - An address phase presented during ERR2 is captured normally (the master may cancel via IDLE).

## Timing
- **Reset values** (on the edge with HRESET=1): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait count 0. Memory contents are not reset.
- **Reset mid-data-phase:** transfer abandoned, no write, outputs go to reset values next cycle.
- **OKAY latency:** the data phase lasts WAIT_STATES+1 cycles after the capture edge.
- **ERROR latency:** exactly 2 cycles.
- HREADYOUT and HRESP are registered. HRDATA comes from the array read at the registered index, so it is valid within the data-phase cycle.
- HREADY=0 with HSEL=1 (another subordinate stalling): no capture; state unchanged.

## Structure
- **Shared package ahb5_pkg gains:**
  - htrans_t, hburst_t, hsize_t enums
  - HRESP_OKAY/HRESP_ERROR constants
  - the slave state enum ahb5_slv_state_t
- **Sub-module ahb5_slave_mem_array:**
  - MEM_DEPTH×32 array
  - 4-bit byte-enable synchronous write port
  - asynchronous read port
  - no reset
- **Top (ahb5_slave_mem):** address-phase register, legality decode, wait counter/FSM, lane decode.

## Test plan
- Reset, WAIT_STATES=0: word write 32'hDEAD_BEEF to 0x10, then read 0x10 → OKAY in 1 cycle each, HRDATA=32'hDEAD_BEEF.
- Byte writes 8'h11/8'h22/8'h33/8'h44 to 0x20..0x23, then word read 0x20 → 32'h4433_2211. Half write 16'hABCD to 0x22, read → 32'hABCD_2211.
- WAIT_STATES=3: read 0x10 → HREADYOUT low 3 cycles, high 4th. HRDATA stable for all 4 cycles.
- Misaligned word at 0x02 and out-of-range at BASE_ADDR+MEM_DEPTH*4 → HRESP=1 with HREADYOUT=0 then 1. Memory is unchanged on readback.
- 4-beat INCR write at 0x40..0x4C, then back-to-back reads, interleaved with BUSY and an HREADY=0 stall → all data correct, no capture during the stall.
- HRESET asserted in the middle of a 3-wait write to 0x50 → next cycle HREADYOUT=1/HRESP=0. Later read of 0x50 returns the pre-write value.
